code_lock_puzzle: RTL and testbench
===================================

// Module: code_lock_puzzle
// PURPOSE
//  Parametrised combination-lock engine for escape-room puzzle stages.
//  Collects NUM_DIGITS digits one at a time and compares them with a secret code.
//  Counts failed attempts and enforces a timed lockout once the attempts run out.
//  Sits between the debounced KEY/SW input conditioning and the HEX/LEDR display logic.
//  One instance per puzzle stage.
// PARAMETERS
//  NUM_DIGITS      4            digits per code entry (>=1)
//  DIGIT_W         4            bits per digit (4 = one hex digit per HEX display)
//  MAX_ATTEMPTS    3            wrong entries allowed before lockout (>=1)
//  LOCKOUT_CYCLES  250000000    lockout duration in clocks (5 s at 50 MHz; >=1)
// PORTS
//  CLOCK_50       in   1                      system clock; all logic on rising edge
//  reset_n        in   1                      synchronous active-low reset
//  code           in   NUM_DIGITS*DIGIT_W     secret code; sampled only in CHECK; first digit in MS field
//  digit_in       in   DIGIT_W                digit value; qualified by digit_valid
//  digit_valid    in   1                      single-cycle pulse: accept digit_in
//  clear          in   1                      single-cycle pulse: discard partial entry
//  entry          out  NUM_DIGITS*DIGIT_W     digits entered so far; newest digit in LS field
//  entry_count    out  $clog2(NUM_DIGITS+1)   number of digits held in entry
//  attempts_left  out  $clog2(MAX_ATTEMPTS+1) wrong entries still allowed
//  solved         out  1                      sticky: correct code entered
//  fail_pulse     out  1                      one-cycle strobe on each wrong entry
//  locked_out     out  1                      high for the whole lockout period
// BEHAVIOUR
//  Reset (reset_n low at a clock edge) overrides everything, in any state:
//   state=ENTRY; entry=0; entry_count=0; attempts_left=MAX_ATTEMPTS;
//   solved=0; fail_pulse=0; locked_out=0; lockout counter=0.
//  All outputs are registered. fail_pulse defaults to 0 on every cycle it is not set.
//  FSM states: ENTRY, CHECK, SOLVED, LOCKOUT.
//  ENTRY:
//   - clear=1: entry<=0, entry_count<=0. clear wins over digit_valid in the same cycle.
//   - digit_valid=1 (clear=0): entry<={entry[(NUM_DIGITS-1)*DIGIT_W-1:0], digit_in};
//     entry_count<=entry_count+1.
//   - If that digit is the NUM_DIGITS-th one, next state is CHECK.
//  CHECK (exactly 1 cycle; digit_valid and clear ignored):
//   - entry==code: ->SOLVED; solved<=1.
//   - mismatch: fail_pulse<=1 for one cycle; entry<=0; entry_count<=0;
//     attempts_left<=attempts_left-1.
//     If attempts_left was 1: ->LOCKOUT; locked_out<=1; counter<=LOCKOUT_CYCLES-1.
//     Otherwise: ->ENTRY.
//  SOLVED: terminal until reset. All inputs ignored. entry keeps the winning code.
//  LOCKOUT: all inputs ignored.
//   - Counter decrements by 1 each cycle.
//   - In the cycle where the counter==0: ->ENTRY; locked_out<=0; attempts_left<=MAX_ATTEMPTS.
//   - locked_out is therefore high for exactly LOCKOUT_CYCLES cycles.
//  Latency: final digit accepted at edge E0 -> CHECK after E0.
//   solved, fail_pulse and locked_out become visible after E1 (2 edges from the final digit).
//  Lockout counter width: $clog2(LOCKOUT_CYCLES+1). No wrap-around; the counter stops at 0.
//  attempts_left never underflows: decrementing from 1 always enters LOCKOUT.
//  code may change at any time; only its value during the CHECK cycle matters.
// TESTING
//  1 Reset, then digits 1,2,3,4 with code=16'h1234
//    -> entry=16'h1234; solved=1 two edges after the 4th digit; fail_pulse never high.
//  2 Digits 1,2,9,9 with code=16'h1234
//    -> fail_pulse high for 1 cycle; attempts_left 3->2; entry=0; entry_count=0; state ENTRY.
//  3 Three wrong entries, LOCKOUT_CYCLES=10
//    -> locked_out high for exactly 10 cycles; digits during lockout ignored;
//       attempts_left reloads to 3 afterwards.
//  4 Digits 1,2 then clear, with digit_valid and clear both high in the same cycle
//    -> entry=0, entry_count=0; next digits 1,2,3,4 solve the lock.
//  5 reset_n low for one edge while in LOCKOUT and while in SOLVED
//    -> all outputs at reset values on the next cycle.
//  6 NUM_DIGITS=6, DIGIT_W=2, code=12'hE4B, entry 3,2,1,0,2,3
//    -> solved=1; a wrong 6-digit entry gives fail_pulse.

Source files
------------

// File: rtl/code_lock_puzzle.sv
// code_lock_puzzle: digit-entry combination lock with attempt counting and timed lockout (in: CLOCK_50, reset_n, code, digit_in, digit_valid, clear; out: entry, entry_count, attempts_left, solved, fail_pulse, locked_out)
module code_lock_puzzle #(
  parameter int NUM_DIGITS     = 4,
  parameter int DIGIT_W        = 4,
  parameter int MAX_ATTEMPTS   = 3,
  parameter int LOCKOUT_CYCLES = 250000000
) (
  input  logic                                CLOCK_50,
  input  logic                                reset_n,
  input  logic [NUM_DIGITS*DIGIT_W-1:0]       code,
  input  logic [DIGIT_W-1:0]                  digit_in,
  input  logic                                digit_valid,
  input  logic                                clear,
  output logic [NUM_DIGITS*DIGIT_W-1:0]       entry,
  output logic [$clog2(NUM_DIGITS+1)-1:0]     entry_count,
  output logic [$clog2(MAX_ATTEMPTS+1)-1:0]   attempts_left,
  output logic                                solved,
  output logic                                fail_pulse,
  output logic                                locked_out
);
  localparam int EW = NUM_DIGITS * DIGIT_W;
  localparam int CW = $clog2(NUM_DIGITS + 1);
  localparam int AW = $clog2(MAX_ATTEMPTS + 1);
  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
  typedef enum logic [1:0] {S_ENTRY, S_CHECK, S_SOLVED, S_LOCKOUT} state_t;
  state_t state;
  logic [LW-1:0] cnt;
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state         <= S_ENTRY;
      entry         <= '0;
      entry_count   <= '0;
      attempts_left <= AW'(MAX_ATTEMPTS);
      solved        <= 1'b0;
      fail_pulse    <= 1'b0;
      locked_out    <= 1'b0;
      cnt           <= '0;
    end else begin
      fail_pulse <= 1'b0;
      case (state)
        S_ENTRY: begin
          if (clear) begin
            entry       <= '0;
            entry_count <= '0;
          end else if (digit_valid) begin
            entry       <= (entry << DIGIT_W) | EW'(digit_in);
            entry_count <= entry_count + CW'(1);
            if (entry_count == CW'(NUM_DIGITS - 1)) state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (entry == code) begin
            state  <= S_SOLVED;
            solved <= 1'b1;
          end else begin
            fail_pulse    <= 1'b1;
            entry         <= '0;
            entry_count   <= '0;
            attempts_left <= attempts_left - AW'(1);
            if (attempts_left == AW'(1)) begin
              state      <= S_LOCKOUT;
              locked_out <= 1'b1;
              cnt        <= LW'(LOCKOUT_CYCLES - 1);
            end else begin
              state <= S_ENTRY;
            end
          end
        end
        S_LOCKOUT: begin
          if (cnt == '0) begin
            state         <= S_ENTRY;
            locked_out    <= 1'b0;
            attempts_left <= AW'(MAX_ATTEMPTS);
          end else begin
            cnt <= cnt - LW'(1);
          end
        end
        default: state <= state;
      endcase
    end
  end
endmodule

// File: tb/tb_code_lock_puzzle.sv
// tb_code_lock_puzzle: directed self-checking bench for code_lock_puzzle (4x4-bit and 6x2-bit instances)
module tb_code_lock_puzzle;
  logic clk = 1'b0;
  logic rst_n;
  logic [15:0] code;
  logic [3:0] digit_in;
  logic digit_valid, clear;
  logic [15:0] entry;
  logic [2:0] entry_count;
  logic [1:0] attempts_left;
  logic solved, fail_pulse, locked_out;
  logic [11:0] b_code, b_entry;
  logic [1:0] b_digit_in;
  logic b_digit_valid, b_clear;
  logic [2:0] b_entry_count;
  logic [1:0] b_attempts_left;
  logic b_solved, b_fail_pulse, b_locked_out;
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  code_lock_puzzle #(.NUM_DIGITS(4), .DIGIT_W(4), .MAX_ATTEMPTS(3), .LOCKOUT_CYCLES(10)) dut (
    .CLOCK_50(clk), .reset_n(rst_n), .code(code), .digit_in(digit_in), .digit_valid(digit_valid),
    .clear(clear), .entry(entry), .entry_count(entry_count), .attempts_left(attempts_left),
    .solved(solved), .fail_pulse(fail_pulse), .locked_out(locked_out));
  code_lock_puzzle #(.NUM_DIGITS(6), .DIGIT_W(2), .MAX_ATTEMPTS(3), .LOCKOUT_CYCLES(10)) dut_b (
    .CLOCK_50(clk), .reset_n(rst_n), .code(b_code), .digit_in(b_digit_in), .digit_valid(b_digit_valid),
    .clear(b_clear), .entry(b_entry), .entry_count(b_entry_count), .attempts_left(b_attempts_left),
    .solved(b_solved), .fail_pulse(b_fail_pulse), .locked_out(b_locked_out));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic dig(input logic [3:0] d);
    digit_in = d;
    digit_valid = 1'b1;
    tick();
    digit_valid = 1'b0;
  endtask
  task automatic b_dig(input logic [1:0] d);
    b_digit_in = d;
    b_digit_valid = 1'b1;
    tick();
    b_digit_valid = 1'b0;
  endtask
  task automatic enter4(input logic [15:0] v);
    for (int i = 3; i >= 0; i--) dig(v[i*4 +: 4]);
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_entry"}, 32'(entry), 32'h0);
    chk({tag, "_count"}, 32'(entry_count), 32'd0);
    chk({tag, "_att"}, 32'(attempts_left), 32'd3);
    chk({tag, "_solved"}, 32'(solved), 32'd0);
    chk({tag, "_fail"}, 32'(fail_pulse), 32'd0);
    chk({tag, "_locked"}, 32'(locked_out), 32'd0);
  endtask
  initial begin
    code = 16'h1234;
    digit_in = '0; digit_valid = 1'b0; clear = 1'b0;
    b_code = 12'hE4B; b_digit_in = '0; b_digit_valid = 1'b0; b_clear = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    chk_reset("reset");
    chk("b_reset_att", 32'(b_attempts_left), 32'd3);
    rst_n = 1'b1;
    enter4(16'h1299);
    chk("wrong1_entry_full", 32'(entry), 32'h1299);
    chk("wrong1_count_full", 32'(entry_count), 32'd4);
    chk("wrong1_fail_early", 32'(fail_pulse), 32'd0);
    tick();
    chk("wrong1_fail", 32'(fail_pulse), 32'd1);
    chk("wrong1_att", 32'(attempts_left), 32'd2);
    chk("wrong1_entry", 32'(entry), 32'h0);
    chk("wrong1_count", 32'(entry_count), 32'd0);
    tick();
    chk("wrong1_fail_once", 32'(fail_pulse), 32'd0);
    dig(4'h5);
    chk("entry_after_fail", 32'(entry), 32'h5);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    enter4(16'h0000);
    tick();
    chk("wrong2_att", 32'(attempts_left), 32'd1);
    chk("wrong2_locked", 32'(locked_out), 32'd0);
    enter4(16'hABCD);
    tick();
    chk("wrong3_fail", 32'(fail_pulse), 32'd1);
    chk("wrong3_att", 32'(attempts_left), 32'd0);
    digit_in = 4'h7;
    digit_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("lock_high_%0d", i), 32'(locked_out), 32'd1);
      tick();
    end
    digit_valid = 1'b0;
    chk("lock_released", 32'(locked_out), 32'd0);
    chk("lock_att_reload", 32'(attempts_left), 32'd3);
    chk("lock_entry_ignored", 32'(entry), 32'h0);
    chk("lock_count_ignored", 32'(entry_count), 32'd0);
    dig(4'h1);
    dig(4'h2);
    chk("partial_entry", 32'(entry), 32'h12);
    digit_in = 4'h9;
    digit_valid = 1'b1;
    clear = 1'b1;
    tick();
    digit_valid = 1'b0;
    clear = 1'b0;
    chk("clear_entry", 32'(entry), 32'h0);
    chk("clear_count", 32'(entry_count), 32'd0);
    enter4(16'h1234);
    chk("solve_entry", 32'(entry), 32'h1234);
    chk("solve_not_yet", 32'(solved), 32'd0);
    code = 16'h1234;
    tick();
    chk("solve_solved", 32'(solved), 32'd1);
    chk("solve_no_fail", 32'(fail_pulse), 32'd0);
    chk("solve_att", 32'(attempts_left), 32'd3);
    code = 16'h0000;
    clear = 1'b1;
    dig(4'h8);
    clear = 1'b0;
    chk("solved_sticky", 32'(solved), 32'd1);
    chk("solved_entry_kept", 32'(entry), 32'h1234);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_reset("rst_solved");
    code = 16'h1234;
    enter4(16'h1111); tick();
    enter4(16'h2222); tick();
    enter4(16'h3333); tick();
    tick(); tick();
    chk("pre_rst_locked", 32'(locked_out), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_reset("rst_lockout");
    for (int i = 0; i < 6; i++) b_dig(2'd0);
    chk("b_full_count", 32'(b_entry_count), 32'd6);
    tick();
    chk("b_wrong_fail", 32'(b_fail_pulse), 32'd1);
    chk("b_wrong_att", 32'(b_attempts_left), 32'd2);
    b_dig(2'd3); b_dig(2'd2); b_dig(2'd1); b_dig(2'd0); b_dig(2'd2); b_dig(2'd3);
    chk("b_entry", 32'(b_entry), 32'hE4B);
    tick();
    chk("b_solved", 32'(b_solved), 32'd1);
    chk("b_no_fail", 32'(b_fail_pulse), 32'd0);
    chk("a_untouched", 32'(entry_count), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
